// File: rtl/target_report_pkg.sv
// Shared types and constants for the target report packer.
//   target_pos_t : one 41-bit target table entry {valid, xmin, ymin, xmax, ymax}
//   rpt_state_e  : packet serialiser states
//   TGT_BYTES    : bytes sent per valid target entry
//   COORD_W      : coordinate field width
package target_report_pkg;

    localparam int TGT_BYTES = 5;
    localparam int COORD_W   = 10;

    typedef struct packed {
        logic               valid;
        logic [COORD_W-1:0] xmin;
        logic [COORD_W-1:0] ymin;
        logic [COORD_W-1:0] xmax;
        logic [COORD_W-1:0] ymax;
    } target_pos_t;

    localparam int POS_W = $bits(target_pos_t);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        FRM,
        CNT,
        TGT,
        CHK
    } rpt_state_e;

endpackage

// File: rtl/target_index_scan.sv
// Combinational priority scan over the target valid vector.
//   valid : one valid bit per table entry
//   start : lowest index to consider (may equal MAX_TARGET, giving no match)
//   idx   : lowest valid index >= start (0 when none)
//   found : a valid index >= start exists
module target_index_scan #(
    parameter int MAX_TARGET = 16
) (
    input  logic [MAX_TARGET-1:0]         valid,
    input  logic [$clog2(MAX_TARGET):0]   start,
    output logic [$clog2(MAX_TARGET)-1:0] idx,
    output logic                          found
);

    localparam int IW = $clog2(MAX_TARGET);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_TARGET; i++) begin
            if (!found && valid[i] && (i >= 32'(start))) begin
                idx   = IW'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/target_report_packer.sv
// Snapshots the target table at each frame end (falling edge of per_frame_vsync)
// and streams it as one byte packet over a valid/ready interface:
//   HDR_BYTE, frame count, number of valid targets, 5 bytes per valid target
//   (bits [39:0], MSB first), optional checksum byte.
// Optional feature macro: TARGET_REPORT_CHECKSUM_EN appends a sum-mod-256 byte
// of all preceding packet bytes and moves m_last onto it.
// Ports:
//   sys_clk, sys_rst         clock, synchronous active-high reset
//   per_frame_vsync          detector vsync; falling edge = frame end
//   target_pos_in            MAX_TARGET x 41-bit entries, entry 0 in the LSBs
//   m_data/m_valid/m_last    packet byte stream, m_ready from the sink
//   frame_cnt                frame ends seen (wraps)
//   drop_sticky              a frame end arrived while a packet was in flight
module target_report_packer
    import target_report_pkg::*;
#(
    parameter int         MAX_TARGET = 16,
    parameter logic [7:0] HDR_BYTE   = 8'hA5
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst,
    input  logic                        per_frame_vsync,
    input  logic [MAX_TARGET*POS_W-1:0] target_pos_in,
    output logic [7:0]                  m_data,
    output logic                        m_valid,
    output logic                        m_last,
    input  logic                        m_ready,
    output logic [7:0]                  frame_cnt,
    output logic                        drop_sticky
);

    localparam int IW = $clog2(MAX_TARGET);

    rpt_state_e      state;
    rpt_state_e      state_next;
    target_pos_t     snap [MAX_TARGET];
    logic [MAX_TARGET-1:0] snap_valid;
    logic [IW-1:0]   cur_idx;
    logic [2:0]      byte_idx;
    logic [IW:0]     num;
    logic [IW:0]     in_count;
    logic [7:0]      fcnt_snap;
    logic            vsync_q;
    logic            frame_end;
    logic            load;
    logic            accept;
    logic            last_tgt_byte;
    logic [IW:0]     scan_start;
    logic [IW-1:0]   scan_idx;
    logic            scan_found;
    logic [39:0]     cur_bits;
    logic [7:0]      tgt_byte;
`ifdef TARGET_REPORT_CHECKSUM_EN
    logic [7:0]      csum;
`endif

    assign frame_end = vsync_q & ~per_frame_vsync;
    assign load      = frame_end && (state == IDLE);

    always_comb begin
        in_count   = '0;
        snap_valid = '0;
        for (int unsigned i = 0; i < MAX_TARGET; i++) begin
            in_count      = in_count + (IW+1)'(target_pos_in[i*POS_W + POS_W - 1]);
            snap_valid[i] = snap[i].valid;
        end
    end

    // One scanner serves both cases: first entry (from CNT) and the entry
    // after the current one (while in TGT).
    assign scan_start = (state == CNT) ? '0 : (IW+1)'(cur_idx) + (IW+1)'(1);

    target_index_scan #(
        .MAX_TARGET(MAX_TARGET)
    ) u_scan (
        .valid(snap_valid),
        .start(scan_start),
        .idx  (scan_idx),
        .found(scan_found)
    );

    always_comb begin
        cur_bits = snap[cur_idx][39:0];
        case (byte_idx)
            3'd0:    tgt_byte = cur_bits[39:32];
            3'd1:    tgt_byte = cur_bits[31:24];
            3'd2:    tgt_byte = cur_bits[23:16];
            3'd3:    tgt_byte = cur_bits[15:8];
            default: tgt_byte = cur_bits[7:0];
        endcase
    end

    assign last_tgt_byte = (byte_idx == 3'(TGT_BYTES - 1)) && !scan_found;

    always_comb begin
        state_next = state;
        m_valid    = (state != IDLE);
        m_data     = '0;
        m_last     = 1'b0;
        accept     = m_valid & m_ready;
        case (state)
            IDLE: if (frame_end) state_next = HDR;
            HDR: begin
                m_data = HDR_BYTE;
                if (accept) state_next = FRM;
            end
            FRM: begin
                m_data = fcnt_snap;
                if (accept) state_next = CNT;
            end
            CNT: begin
                m_data = 8'(num);
                if (num == '0) begin
`ifdef TARGET_REPORT_CHECKSUM_EN
                    if (accept) state_next = CHK;
`else
                    m_last = 1'b1;
                    if (accept) state_next = IDLE;
`endif
                end else if (accept) begin
                    state_next = TGT;
                end
            end
            TGT: begin
                m_data = tgt_byte;
                if (last_tgt_byte) begin
`ifdef TARGET_REPORT_CHECKSUM_EN
                    if (accept) state_next = CHK;
`else
                    m_last = 1'b1;
                    if (accept) state_next = IDLE;
`endif
                end
            end
            CHK: begin
`ifdef TARGET_REPORT_CHECKSUM_EN
                m_data = csum;
                m_last = 1'b1;
                if (accept) state_next = IDLE;
`else
                state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_next;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            vsync_q     <= 1'b0;
            frame_cnt   <= '0;
            drop_sticky <= 1'b0;
            cur_idx     <= '0;
            byte_idx    <= '0;
            num         <= '0;
            fcnt_snap   <= '0;
`ifdef TARGET_REPORT_CHECKSUM_EN
            csum        <= '0;
`endif
        end else begin
            vsync_q <= per_frame_vsync;
            if (frame_end) begin
                frame_cnt <= frame_cnt + 8'd1;
                if (state != IDLE) drop_sticky <= 1'b1;
            end
            if (load) begin
                num       <= in_count;
                fcnt_snap <= frame_cnt;
`ifdef TARGET_REPORT_CHECKSUM_EN
                csum      <= '0;
`endif
            end
            if (accept) begin
`ifdef TARGET_REPORT_CHECKSUM_EN
                csum <= csum + m_data;
`endif
                if (state == CNT) begin
                    cur_idx  <= scan_idx;
                    byte_idx <= '0;
                end else if (state == TGT) begin
                    if (byte_idx == 3'(TGT_BYTES - 1)) begin
                        byte_idx <= '0;
                        cur_idx  <= scan_idx;
                    end else begin
                        byte_idx <= byte_idx + 3'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst && load) begin
            for (int unsigned i = 0; i < MAX_TARGET; i++) begin
                snap[i] <= target_pos_in[i*POS_W +: POS_W];
            end
        end
    end

endmodule

// File: tb/tb_target_report_packer.sv
// Directed bench for target_report_packer: table of valid-mask vectors with
// hand-computed num/length, plus sequences for back-pressure, dropped frame
// end, mid-packet reset and frame counter wrap.
module tb_target_report_packer;

    localparam int NT = 16;
    localparam int PW = 41;
`ifdef TARGET_REPORT_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    typedef struct {
        logic [15:0] vmask;
        int          exp_num;
        int          exp_len;   // without the optional checksum byte
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             vsync;
    logic [NT*PW-1:0] tpos;
    logic [7:0]       m_data;
    logic             m_valid;
    logic             m_last;
    logic             m_ready;
    logic [7:0]       frame_cnt;
    logic             drop_sticky;

    int          checks = 0;
    int          errors = 0;
    int          exp_fc = 0;
    logic [15:0] lfsr = 16'hACE1;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic        last_q[$];
    int          gaps;

    always #5 clk = ~clk;

    target_report_packer #(
        .MAX_TARGET(16),
        .HDR_BYTE  (8'hA5)
    ) dut (
        .sys_clk        (clk),
        .sys_rst        (rst),
        .per_frame_vsync(vsync),
        .target_pos_in  (tpos),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_last         (m_last),
        .m_ready        (m_ready),
        .frame_cnt      (frame_cnt),
        .drop_sticky    (drop_sticky)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NT*PW-1:0] mk_targets(input logic [15:0] vm);
        logic [NT*PW-1:0] t;
        logic [40:0]      e;
        for (int i = 0; i < NT; i++) begin
            e[40]    = vm[i];
            e[39:32] = 8'($urandom());
            e[31:0]  = $urandom();
            t[i*PW +: PW] = e;
        end
        return t;
    endfunction

    task automatic build_exp(input logic [NT*PW-1:0] t, input logic [7:0] fc);
        logic [7:0] sum;
        logic [7:0] b8;
        int         n;
        n = 0;
        for (int i = 0; i < NT; i++) if (t[i*PW + 40]) n++;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(fc);
        exp_q.push_back(8'(n));
        for (int i = 0; i < NT; i++) begin
            if (t[i*PW + 40]) begin
                for (int b = 0; b < 5; b++) begin
                    b8 = t[i*PW + 32 - 8*b +: 8];
                    exp_q.push_back(b8);
                end
            end
        end
        sum = 8'h00;
        foreach (exp_q[k]) sum = sum + exp_q[k];
        if (CS == 1) exp_q.push_back(sum);
    endtask

    task automatic frame_end();
        @(negedge clk);
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        exp_fc = (exp_fc + 1) % 256;
    endtask

    // rdy_mode 0: m_ready held 1; 1: m_ready from LFSR.
    // act 1: when act_at bytes accepted, stall and issue another frame end.
    // act 2: when act_at bytes accepted, pulse reset and stop.
    task automatic recv(input int rdy_mode, input int act_at, input int act);
        int         cyc;
        bit         done;
        bit         acted;
        bit         holding;
        logic [7:0] hd;
        logic       hl;
        logic [7:0] ad;
        got_q.delete();
        last_q.delete();
        gaps = 0; cyc = 0; done = 0; acted = 0; holding = 0; hd = '0; hl = 1'b0;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            // snapshot was taken on the previous edge; inputs may now change
            if (cyc == 1) tpos = mk_targets(16'($urandom()));
            if (holding && m_valid) begin
                chk("hold_data", 32'(m_data), 32'(hd));
                chk("hold_last", 32'(m_last), 32'(hl));
            end
            holding = 0;
            if (act != 0 && !acted && got_q.size() == act_at && m_valid) begin
                acted = 1;
                if (act == 1) begin
                    ad = m_data;
                    m_ready = 1'b0;
                    vsync = 1'b1;
                    @(negedge clk);
                    vsync = 1'b0;
                    @(negedge clk);
                    cyc += 2;
                    exp_fc = (exp_fc + 1) % 256;
                    chk("drop_sticky", 32'(drop_sticky), 32'd1);
                    chk("drop_frame_cnt", 32'(frame_cnt), 32'(exp_fc));
                    chk("drop_hold_data", 32'(m_data), 32'(ad));
                    chk("drop_valid", 32'(m_valid), 32'd1);
                end else begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    exp_fc = 0;
                    chk("rst_m_valid", 32'(m_valid), 32'd0);
                    chk("rst_m_last", 32'(m_last), 32'd0);
                    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
                    chk("rst_drop_sticky", 32'(drop_sticky), 32'd0);
                    return;
                end
            end
            m_ready = (rdy_mode == 0) ? 1'b1 : lfsr[0];
            lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            if (m_valid && m_ready) begin
                got_q.push_back(m_data);
                last_q.push_back(m_last);
                if (m_last) done = 1;
            end else if (m_valid) begin
                holding = 1;
                hd = m_data;
                hl = m_last;
            end else if (got_q.size() != 0) begin
                gaps++;
            end
        end
        chk("recv_complete", 32'(done), 32'd1);
    endtask

    task automatic compare_pkt(input string tag);
        int n;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        chk({tag, " len"}, 32'(got_q.size()), 32'(exp_q.size()));
        chk({tag, " valid_gaps"}, 32'(gaps), 32'd0);
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s data[%0d]", tag, k), 32'(got_q[k]), 32'(exp_q[k]));
            chk($sformatf("%s last[%0d]", tag, k), 32'(last_q[k]), 32'(k == exp_q.size() - 1));
        end
    endtask

    task automatic run_frame(input logic [15:0] vm, input int rdy_mode, input string tag);
        logic [7:0] fc;
        tpos = mk_targets(vm);
        fc = 8'(exp_fc);
        build_exp(tpos, fc);
        frame_end();
        recv(rdy_mode, 0, 0);
        compare_pkt(tag);
    endtask

    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] fc;

        vecs[0] = '{16'h0204, 2, 13};
        vecs[1] = '{16'h0000, 0, 3};
        vecs[2] = '{16'hFFFF, 16, 83};
        vecs[3] = '{16'h8001, 2, 13};
        vecs[4] = '{16'h8000, 1, 8};
        vecs[5] = '{16'h5A5A, 8, 43};

        rst = 1'b1; vsync = 1'b0; m_ready = 1'b0; tpos = '0;
        repeat (3) @(negedge clk);
        chk("reset m_valid", 32'(m_valid), 32'd0);
        chk("reset m_last", 32'(m_last), 32'd0);
        chk("reset m_data", 32'(m_data), 32'd0);
        chk("reset frame_cnt", 32'(frame_cnt), 32'd0);
        chk("reset drop_sticky", 32'(drop_sticky), 32'd0);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            run_frame(vecs[v].vmask, 0, $sformatf("vec%0d", v));
            chk($sformatf("vec%0d table_len", v), 32'(got_q.size()), 32'(vecs[v].exp_len + CS));
            if (got_q.size() >= 3) begin
                chk($sformatf("vec%0d num", v), 32'(got_q[2]), 32'(vecs[v].exp_num));
            end
        end
        chk("no_drop_yet", 32'(drop_sticky), 32'd0);

        run_frame(16'hFFFF, 1, "backpressure");

        tpos = mk_targets(16'hFFFF);
        fc = 8'(exp_fc);
        build_exp(tpos, fc);
        frame_end();
        recv(0, 19, 1);
        compare_pkt("drop_pkt");
        run_frame(16'h0204, 0, "after_drop");

        tpos = mk_targets(16'hFFFF);
        frame_end();
        recv(0, 6, 2);
        run_frame(16'h0410, 0, "after_reset");
        if (got_q.size() >= 2) chk("after_reset frm", 32'(got_q[1]), 32'h00);

        for (int f = 0; f < 255; f++) run_frame(16'h0000, 0, $sformatf("wrap%0d", f));
        chk("wrap frame_cnt", 32'(frame_cnt), 32'h00);
        run_frame(16'h0000, 0, "wrap_last");
        if (got_q.size() >= 2) chk("wrap frm", 32'(got_q[1]), 32'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
